// File: rtl/armleocpu_bus_pkg.sv
// Shared encodings and field widths for the ArmleoCPU cache-side memory bus.
package armleocpu_bus_pkg;

  localparam int ADDR_W  = 34;
  localparam int BURST_W = 4;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int CMD_W   = 3;
  localparam int RESP_W  = 3;

  localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd2;

  localparam logic [RESP_W-1:0] RESP_OK  = 3'd0;
  localparam logic [RESP_W-1:0] RESP_ERR = 3'd1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/armleocpu_rr_picker.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping.
module armleocpu_rr_picker #(
  parameter int CHANNELS = 2,
  parameter int GRANT_W  = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GRANT_W-1:0]  rr_ptr,
  output logic                valid,
  output logic [GRANT_W-1:0]  index
);

  logic [2*CHANNELS-1:0] rotated;
  int                    sum;

  always_comb begin
    rotated = {req, req} >> rr_ptr;
    valid   = 1'b0;
    index   = '0;
    sum     = 0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        sum = int'(rr_ptr) + i;
        if (sum >= CHANNELS) sum = sum - CHANNELS;
        valid = 1'b1;
        index = GRANT_W'(sum);
      end
    end
  end

endmodule

// File: rtl/armleocpu_bus_arbiter.sv
// Round-robin N-channel arbiter holding the grant for a whole transaction (incl. read bursts).
// Optional watchdog: define ARMLEOCPU_ARBITER_TIMEOUT_EN to force an error completion on a hung slave.
module armleocpu_bus_arbiter
  import armleocpu_bus_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int GRANT_W        = $clog2(CHANNELS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          s_transaction,
  input  logic [CMD_W*CHANNELS-1:0]    s_cmd,
  input  logic [ADDR_W*CHANNELS-1:0]   s_address,
  input  logic [BURST_W*CHANNELS-1:0]  s_burstcount,
  input  logic [DATA_W*CHANNELS-1:0]   s_wdata,
  input  logic [BE_W*CHANNELS-1:0]     s_wbyte_enable,
  output logic [CHANNELS-1:0]          s_transaction_done,
  output logic [RESP_W*CHANNELS-1:0]   s_transaction_response,
  output logic [DATA_W-1:0]            s_rdata,
  output logic                         m_transaction,
  output logic [CMD_W-1:0]             m_cmd,
  output logic [ADDR_W-1:0]            m_address,
  output logic [BURST_W-1:0]           m_burstcount,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [BE_W-1:0]              m_wbyte_enable,
  input  logic                         m_transaction_done,
  input  logic [RESP_W-1:0]            m_transaction_response,
  input  logic [DATA_W-1:0]            m_rdata
);

  if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
    $error("armleocpu_bus_arbiter: CHANNELS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("armleocpu_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [BURST_W-1:0] last_beat_index(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? '0 : bc - 1'b1;
  endfunction

  function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] g);
    return (g == GRANT_W'(CHANNELS - 1)) ? '0 : g + 1'b1;
  endfunction

  arb_state_t           state;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [GRANT_W-1:0]   grant;
  logic [BURST_W-1:0]   beat_cnt;
  logic [BURST_W-1:0]   burst_last;

  logic                 pick_valid;
  logic [GRANT_W-1:0]   pick_idx;
  logic [BURST_W-1:0]   pick_burst;
  logic                 busy;
  logic                 timeout_hit;
  logic                 beat_done;
  logic                 last_beat;
  logic                 complete;
  logic [CMD_W-1:0]     sel_cmd;

  armleocpu_rr_picker #(
    .CHANNELS (CHANNELS),
    .GRANT_W  (GRANT_W)
  ) u_picker (
    .req    (s_transaction),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  assign busy       = (state == BUSY);
  assign pick_burst = s_burstcount[pick_idx*BURST_W +: BURST_W];
  assign sel_cmd    = s_cmd[grant*CMD_W +: CMD_W];

  assign m_transaction  = busy && s_transaction[grant] && !timeout_hit;
  assign m_cmd          = busy ? sel_cmd : '0;
  assign m_address      = busy ? s_address[grant*ADDR_W +: ADDR_W] : '0;
  assign m_burstcount   = busy ? s_burstcount[grant*BURST_W +: BURST_W] : '0;
  assign m_wdata        = busy ? s_wdata[grant*DATA_W +: DATA_W] : '0;
  assign m_wbyte_enable = busy ? s_wbyte_enable[grant*BE_W +: BE_W] : '0;
  assign s_rdata        = m_rdata;

  // An error response terminates a burst early regardless of the beat count.
  assign beat_done = busy && m_transaction_done;
  assign last_beat = (sel_cmd != CMD_READ) || (m_transaction_response != RESP_OK) ||
                     (beat_cnt == burst_last);
  assign complete  = (beat_done && last_beat) || timeout_hit;

  always_comb begin
    s_transaction_done     = '0;
    s_transaction_response = '0;
    if (busy) begin
      s_transaction_done[grant] = m_transaction_done || timeout_hit;
      s_transaction_response[grant*RESP_W +: RESP_W] = timeout_hit ? RESP_ERR : m_transaction_response;
    end
  end

`ifdef ARMLEOCPU_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wdog;

  assign timeout_hit = busy && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !busy || m_transaction_done) wdog <= '0;
    else                                    wdog <= wdog + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      beat_cnt   <= '0;
      burst_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= BUSY;
            grant      <= pick_idx;
            beat_cnt   <= '0;
            burst_last <= last_beat_index(pick_burst);
          end
        end
        BUSY: begin
          if (complete) begin
            state  <= IDLE;
            rr_ptr <= next_ptr(grant);
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A granted master must hold its request until its final done beat.
  always_ff @(posedge clk) begin
    if (!rst && busy && !timeout_hit) begin
      assert (s_transaction[grant]);
    end
  end

endmodule

// File: doc/armleocpu_bus_arbiter.md
Name: armleocpu_bus_arbiter

Overview:
- Parametrised N-channel arbiter that merges CHANNELS cache-side memory buses (i_/d_ style: transaction/cmd/address/burstcount/wdata/wbyte_enable/rdata) onto one shared memory bus.
- Replaces separate I and D bus ports at the CPU top and scales to extra masters (PTW, debug, DMA).
- Round-robin grant is held for a whole transaction, including read bursts.

Parameters:
- CHANNELS, 2: number of requesting ports, 2..8.
- GRANT_W, $clog2(CHANNELS): width of the grant index; derived, not to be overridden.
- TIMEOUT_CYCLES, 1024: cycle limit for the watchdog; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_transaction  in  CHANNELS  per-port request, held until that port's done on the final beat.
- s_cmd  in  3*CHANNELS  per-port command.
- s_address  in  34*CHANNELS  per-port physical address.
- s_burstcount  in  4*CHANNELS  per-port beat count.
- s_wdata  in  32*CHANNELS  per-port write data.
- s_wbyte_enable  in  4*CHANNELS  per-port byte enables.
- s_transaction_done  out  CHANNELS  per-beat done, routed to the granted port only.
- s_transaction_response  out  3*CHANNELS  response, valid with done.
- s_rdata  out  32  read data, broadcast to all ports.
- m_transaction  out  1  shared-bus request.
- m_cmd  out  3  shared-bus command.
- m_address  out  34  shared-bus address.
- m_burstcount  out  4  shared-bus beat count.
- m_wdata  out  32  shared-bus write data.
- m_wbyte_enable  out  4  shared-bus byte enables.
- m_transaction_done  in  1  shared-bus per-beat done.
- m_transaction_response  in  3  shared-bus response.
- m_rdata  in  32  shared-bus read data.

Behaviour:
- Reset (rst at clk edge):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - All m_* outputs 0; all s_transaction_done 0.
  - A reset during BUSY aborts at that edge; no done pulse is issued to any port.
- IDLE:
  - Outputs m_transaction=0 and all done=0.
  - If any s_transaction is set, grant the first set bit searching upward from rr_ptr, wrapping modulo CHANNELS.
  - Latch grant and that port's burstcount, clear beat_cnt, go to BUSY.
  - Arbitration latency is exactly 1 cycle from request to m_transaction.
- BUSY:
  - m_transaction = s_transaction[grant].
  - m_cmd, m_address, m_burstcount, m_wdata, m_wbyte_enable are combinational from port grant.
  - s_transaction_done[grant] = m_transaction_done; the response is routed to the same port. Non-granted ports see done=0 and response=0.
- Completion of a transaction:
  - READ: ends on the done beat where beat_cnt == max(latched burstcount,1)-1; otherwise beat_cnt increments on each done.
  - WRITE and any other cmd: ends on the first done.
  - Any response != RESP_OK ends the transaction on that beat, whatever beat_cnt is.
- On completion: go to IDLE and set rr_ptr = grant+1 (wrap to 0 at CHANNELS). The next grant follows one idle cycle.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
  - CHANNELS=2 with both ports requesting continuously alternates 0,1,0,1.
- Protocol violations:
  - A granted port dropping s_transaction before completion is illegal.
  - The arbiter stays BUSY and m_transaction falls with it; a simulation assertion fires.
- Burstcount 0 is treated as 1 beat.
- Register count is CHANNELS-independent apart from GRANT_W; no combinational path from m_transaction_done to any m_* output.

Optional Feature:
- Macro: ARMLEOCPU_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to BUSY and on every m_transaction_done.
  - Reaching TIMEOUT_CYCLES-1 in BUSY forces s_transaction_done[grant]=1 with response RESP_ERR for one cycle, then goes to IDLE and advances rr_ptr.
  - m_transaction drops in that same cycle.
- Not defined: no counter is built, and BUSY waits indefinitely.

Decomposition:
- Package armleocpu_bus_pkg holds:
  - Commands: CMD_NONE=3'd0, CMD_READ=3'd1, CMD_WRITE=3'd2.
  - Responses: RESP_OK=3'd0, RESP_ERR=3'd1.
  - State encodings: IDLE=1'b0, BUSY=1'b1.
  - The field widths 34/4/32/4.
- Sub-module armleocpu_rr_picker: combinational round-robin priority search of CHANNELS request bits from rr_ptr, returning a valid bit and GRANT_W index.

Test Plan:
- Single read, port 1, burstcount=4, address=34'h1000:
  - m_transaction rises 1 cycle after the request.
  - Four done beats reach port 1 only, with rdata 0xA0..0xA3.
  - Returns to IDLE after beat 4.
- Ports 0 and 1 both request single-beat writes from reset: grants go 0 then 1, each m_cmd=CMD_WRITE, with 1 idle cycle between them.
- CHANNELS=4, ports 1 and 3 request continuously: grant sequence 1,3,1,3; ports 0 and 2 never see done.
- Read burstcount=8 with response RESP_ERR on beat 3: port gets done+RESP_ERR on beat 3, then IDLE; beats 4–8 are not waited for.
- rst asserted in beat 2 of a 4-beat read: at the next edge m_transaction=0 and all done=0; the next request is granted from rr_ptr=0.
- With ARMLEOCPU_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never responds: port gets done with RESP_ERR exactly 16 cycles after grant.
